core_wbu_ctrl: RTL and testbench
================================

Name: core_wbu_ctrl

Overview:
- Registered write-back stage sitting between the execute stage and the register file / difftest commit interface.
- Accepts one retiring instruction per handshake and selects the write-back source: ALU, LSU or CSR-ALU.
- For LSU instructions it stalls the execute stage until the LSU result returns, with a configurable timeout.
- Produces one-cycle registered register-file write and commit pulses.

Parameters:
- XLEN, 32, datapath width of results, write-back data and PC.
- RA_W, 5, register address width.
- LSU_TIMEOUT, 256, maximum cycles spent in WAIT_LSU before abort; 0 disables the timeout.
- ZERO_SUPPRESS, 1, when 1 a write to rd address 0 never asserts wb_en.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  execute stage presents a retiring instruction.
- ex_ready  out  1  stage can accept; high iff state==IDLE (combinational from state).
- ex_rd_wen  in  1  instruction writes rd.
- ex_rd_addr  in  RA_W  destination register.
- ex_pc  in  XLEN  PC of instruction.
- ex_lsu_used  in  1  result comes from LSU.
- ex_csr_wr_en  in  1  result comes from CSR-ALU (ignored if ex_lsu_used).
- ex_alu_result  in  XLEN  ALU result.
- ex_csr_result  in  XLEN  CSR-ALU result.
- lsu_valid  in  1  LSU result valid this cycle (single-cycle pulse).
- lsu_result  in  XLEN  LSU load data.
- wb_en  out  1  register-file write strobe, registered.
- wb_addr  out  RA_W  write address, registered.
- wb_data  out  XLEN  write data, registered.
- commit_valid  out  1  one-cycle retire pulse for difftest, registered.
- commit_pc  out  XLEN  PC of retired instruction.
- timeout_err  out  1  sticky: an LSU wait aborted by timeout.

Behaviour:
- Reset:
  - state=IDLE; wait counter=0.
  - wb_en=0, wb_addr=0, wb_data=0, commit_valid=0, commit_pc=0, timeout_err=0.
  - Reset asserted mid-WAIT_LSU drops the pending instruction; no commit.
- Handshake: transfer occurs when ex_valid & ex_ready. Inputs are sampled only on transfer.
- Source select:
  - data = ex_lsu_used ? lsu_result : ex_csr_wr_en ? ex_csr_result : ex_alu_result.
  - effective write enable = rd_wen & ~(ZERO_SUPPRESS & rd_addr==0).
- IDLE:
  - Transfer with ex_lsu_used=0: next cycle wb_en=effective wen, wb_addr, wb_data=selected data, commit_valid=1, commit_pc=ex_pc. Latency 1. Stay IDLE.
  - Transfer with ex_lsu_used=1 and lsu_valid=1 in the same cycle: complete as above with lsu_result. Latency 1.
  - Transfer with ex_lsu_used=1 and lsu_valid=0: latch rd_wen, rd_addr and pc; counter=0; go to WAIT_LSU.
  - No transfer: wb_en=0, commit_valid=0 next cycle.
- WAIT_LSU (ex_ready=0):
  - lsu_valid=1: next cycle write back latched rd with lsu_result, commit_valid=1, commit_pc=latched pc; go to IDLE.
  - lsu_valid=0 and LSU_TIMEOUT!=0 and counter==LSU_TIMEOUT-1: next cycle commit_valid=1, wb_en=0, timeout_err=1; go to IDLE.
  - Otherwise counter+1, outputs idle.
  - lsu_valid takes priority over timeout in the same cycle.
  - Counter width is clog2(LSU_TIMEOUT+1); counter does not increment when the timeout is disabled.
- Pulses and ordering:
  - wb_en and commit_valid are never high for more than one cycle per instruction.
  - Back-to-back non-LSU transfers produce pulses on consecutive cycles.
  - lsu_valid while IDLE with no LSU transfer is ignored.
- timeout_err clears only on reset.
- wb_addr and wb_data hold their last value when wb_en=0; they are not cleared.

Test Plan:
- Reset, then ALU op rd=3, ex_alu_result=0x1234, pc=0x80000000 -> next cycle wb_en=1, wb_addr=3, wb_data=0x1234, commit_valid=1, commit_pc=0x80000000; following cycle both pulses 0.
- CSR op with ex_csr_wr_en=1, csr_result=0xABCD, alu_result=0x1111, rd=5 -> wb_data=0xABCD. Then ALU op with rd=0 -> wb_en=0, commit_valid=1.
- LSU op rd=7, lsu_valid arriving 4 cycles after transfer with 0xDEADBEEF:
  - ex_ready=0 for 4 cycles.
  - A new ex_valid presented during the wait is not accepted.
  - Cycle after lsu_valid: wb_en=1, wb_addr=7, wb_data=0xDEADBEEF, commit_pc = the LSU instruction's pc.
  - ex_ready=1 in that same cycle.
- LSU op with lsu_valid in the accept cycle -> 1-cycle latency, ex_ready never drops. Follow with a back-to-back ALU op -> consecutive commit pulses.
- LSU_TIMEOUT=8, LSU op with no lsu_valid:
  - Commit pulse with wb_en=0 and timeout_err=1, 9 cycles after transfer.
  - Then a normal ALU op retires with timeout_err still 1.
- rst_n deasserted asynchronously mid-WAIT_LSU -> outputs 0 immediately, no commit after reset release, ex_ready=1.

Source files
------------

// File: rtl/core_wbu_ctrl.sv
// Write-back stage controller: selects the ALU/LSU/CSR result, stalls execute while a load
// is outstanding, and emits registered register-file write and commit pulses.
module core_wbu_ctrl #(
  parameter int XLEN          = 32,
  parameter int RA_W          = 5,
  parameter int LSU_TIMEOUT   = 256,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_rd_wen,
  input  logic [RA_W-1:0] ex_rd_addr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_lsu_used,
  input  logic            ex_csr_wr_en,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_csr_result,
  input  logic            lsu_valid,
  input  logic [XLEN-1:0] lsu_result,
  output logic            wb_en,
  output logic [RA_W-1:0] wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic            timeout_err
);

  // state    | meaning
  // IDLE     | ready for a retiring instruction
  // WAIT_LSU | load accepted, waiting for lsu_valid or timeout
  typedef enum logic {IDLE, WAIT_LSU} state_t;

  localparam bit TIMEOUT_EN = (LSU_TIMEOUT != 0);
  localparam int CW = TIMEOUT_EN ? $clog2(LSU_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = TIMEOUT_EN ? CW'(LSU_TIMEOUT - 1) : '0;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            pend_wen;
  logic [RA_W-1:0] pend_addr;
  logic [XLEN-1:0] pend_pc;

  logic            xfer;
  logic            eff_wen;
  logic [XLEN-1:0] sel_data;

  assign ex_ready = (state == IDLE);
  assign xfer     = ex_valid & ex_ready;
  assign eff_wen  = ex_rd_wen & ~(ZERO_SUPPRESS & (ex_rd_addr == '0));
  assign sel_data = ex_lsu_used  ? lsu_result    :
                    ex_csr_wr_en ? ex_csr_result : ex_alu_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pend_wen     <= 1'b0;
      pend_addr    <= '0;
      pend_pc      <= '0;
      wb_en        <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      timeout_err  <= 1'b0;
    end else begin
      wb_en        <= 1'b0;
      commit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (!ex_lsu_used || lsu_valid) begin
              // wb_addr/wb_data only move when a write actually happens
              wb_en        <= eff_wen;
              commit_valid <= 1'b1;
              commit_pc    <= ex_pc;
              if (eff_wen) begin
                wb_addr <= ex_rd_addr;
                wb_data <= sel_data;
              end
            end else begin
              pend_wen  <= eff_wen;
              pend_addr <= ex_rd_addr;
              pend_pc   <= ex_pc;
              cnt       <= '0;
              state     <= WAIT_LSU;
            end
          end
        end
        WAIT_LSU: begin
          if (lsu_valid) begin
            wb_en        <= pend_wen;
            commit_valid <= 1'b1;
            commit_pc    <= pend_pc;
            if (pend_wen) begin
              wb_addr <= pend_addr;
              wb_data <= lsu_result;
            end
            state <= IDLE;
          end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
            // aborted load still retires so the commit stream stays in order
            commit_valid <= 1'b1;
            commit_pc    <= pend_pc;
            timeout_err  <= 1'b1;
            state        <= IDLE;
          end else if (TIMEOUT_EN) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_wbu_ctrl.sv
// Directed bench for core_wbu_ctrl: single-cycle vector table plus sequences for
// load wait, timeout and reset during a pending load.
module tb_core_wbu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_rd_wen, ex_lsu_used, ex_csr_wr_en;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_pc, ex_alu_result, ex_csr_result;
  logic        lsu_valid;
  logic [31:0] lsu_result;
  logic        wb_en, commit_valid, timeout_err;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, commit_pc;

  int checks = 0;
  int errors = 0;

  core_wbu_ctrl #(.XLEN(32), .RA_W(5), .LSU_TIMEOUT(8), .ZERO_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd_wen(ex_rd_wen),
    .ex_rd_addr(ex_rd_addr), .ex_pc(ex_pc), .ex_lsu_used(ex_lsu_used),
    .ex_csr_wr_en(ex_csr_wr_en), .ex_alu_result(ex_alu_result),
    .ex_csr_result(ex_csr_result), .lsu_valid(lsu_valid), .lsu_result(lsu_result),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, wen, lsu, csr, lv;
    logic [4:0]  rd;
    logic [31:0] pc, alu, csrv, lres;
    logic        e_wb;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_commit;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic wen, input logic [4:0] rd, input logic [31:0] pc,
                       input logic lsu, input logic csr, input logic [31:0] alu,
                       input logic [31:0] csrv, input logic lv, input logic [31:0] lres);
    ex_valid = v; ex_rd_wen = wen; ex_rd_addr = rd; ex_pc = pc;
    ex_lsu_used = lsu; ex_csr_wr_en = csr; ex_alu_result = alu;
    ex_csr_result = csrv; lsu_valid = lv; lsu_result = lres;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        valid wen  lsu  csr  lv   rd     pc            alu           csr           lres
    vecs[0] = '{1, 1, 0, 0, 0, 5'd3,  32'h8000_0000, 32'h0000_1234, 32'h0, 32'h0,
                1, 5'd3,  32'h0000_1234, 1};
    vecs[1] = '{0, 1, 0, 0, 0, 5'd4,  32'h8000_0004, 32'h0000_9999, 32'h0, 32'h0,
                0, 5'd0,  32'h0, 0};
    vecs[2] = '{1, 1, 0, 1, 0, 5'd5,  32'h8000_0008, 32'h0000_1111, 32'h0000_ABCD, 32'h0,
                1, 5'd5,  32'h0000_ABCD, 1};
    vecs[3] = '{1, 1, 0, 0, 0, 5'd0,  32'h8000_000C, 32'h0000_5555, 32'h0, 32'h0,
                0, 5'd0,  32'h0, 1};
    vecs[4] = '{1, 1, 1, 0, 1, 5'd9,  32'h8000_0010, 32'h0000_7777, 32'h0, 32'hCAFE_F00D,
                1, 5'd9,  32'hCAFE_F00D, 1};
    vecs[5] = '{1, 1, 0, 0, 0, 5'd10, 32'h8000_0014, 32'h0000_0042, 32'h0, 32'h0,
                1, 5'd10, 32'h0000_0042, 1};
    vecs[6] = '{1, 0, 0, 0, 0, 5'd11, 32'h8000_0018, 32'h0000_0043, 32'h0, 32'h0,
                0, 5'd0,  32'h0, 1};
    vecs[7] = '{0, 0, 0, 0, 1, 5'd12, 32'h8000_001C, 32'h0, 32'h0, 32'h1357_9BDF,
                0, 5'd0,  32'h0, 0};
    vecs[8] = '{1, 1, 1, 1, 1, 5'd13, 32'h8000_0020, 32'h0000_0001, 32'h0000_0002, 32'h0BAD_F00D,
                1, 5'd13, 32'h0BAD_F00D, 1};
    vecs[9] = '{0, 1, 1, 0, 1, 5'd14, 32'h8000_0024, 32'h0, 32'h0, 32'h2222_2222,
                0, 5'd0,  32'h0, 0};

    rst_n = 1'b0;
    idle_in();
    tick(); tick();
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_commit", commit_valid, 0);
    chk("rst_commit_pc", commit_pc, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_ready", ex_ready, 1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].wen, vecs[i].rd, vecs[i].pc, vecs[i].lsu, vecs[i].csr,
            vecs[i].alu, vecs[i].csrv, vecs[i].lv, vecs[i].lres);
      tick();
      chk($sformatf("v%0d_wb_en", i), wb_en, vecs[i].e_wb);
      chk($sformatf("v%0d_commit", i), commit_valid, vecs[i].e_commit);
      chk($sformatf("v%0d_ready", i), ex_ready, 1);
      if (vecs[i].e_commit) chk($sformatf("v%0d_commit_pc", i), commit_pc, vecs[i].pc);
      if (vecs[i].e_wb) begin
        chk($sformatf("v%0d_wb_addr", i), wb_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_data);
      end
    end
    idle_in();
    tick();
    chk("post_vec_wb_en", wb_en, 0);
    chk("post_vec_commit", commit_valid, 0);

    // load returning four cycles after transfer, with a competing op presented during the wait
    drive(1, 1, 5'd7, 32'h8000_0100, 1, 0, 32'h0, 32'h0, 0, 32'h0);
    tick();
    chk("lw_c1_ready", ex_ready, 0);
    chk("lw_c1_commit", commit_valid, 0);
    drive(1, 1, 5'd8, 32'h8000_0200, 0, 0, 32'h5A5A_5A5A, 32'h0, 0, 32'h0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("lw_c%0d_ready", c), ex_ready, 0);
      chk($sformatf("lw_c%0d_commit", c), commit_valid, 0);
      chk($sformatf("lw_c%0d_wb_en", c), wb_en, 0);
    end
    ex_valid = 0;
    lsu_valid = 1; lsu_result = 32'hDEAD_BEEF;
    tick();
    chk("lw_wb_en", wb_en, 1);
    chk("lw_wb_addr", wb_addr, 7);
    chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("lw_commit", commit_valid, 1);
    chk("lw_commit_pc", commit_pc, 32'h8000_0100);
    chk("lw_ready", ex_ready, 1);
    idle_in();
    tick();
    chk("lw_after_wb_en", wb_en, 0);
    chk("lw_after_commit", commit_valid, 0);
    chk("lw_no_timeout", timeout_err, 0);

    // load with no response: timeout commit nine cycles after transfer
    drive(1, 1, 5'd12, 32'h8000_0300, 1, 0, 32'h0, 32'h0, 0, 32'h0);
    tick();
    idle_in();
    chk("to_c1_ready", ex_ready, 0);
    chk("to_c1_commit", commit_valid, 0);
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk($sformatf("to_c%0d_commit", c), commit_valid, 0);
      chk($sformatf("to_c%0d_ready", c), ex_ready, 0);
      chk($sformatf("to_c%0d_err", c), timeout_err, 0);
    end
    tick();
    chk("to_commit", commit_valid, 1);
    chk("to_wb_en", wb_en, 0);
    chk("to_err", timeout_err, 1);
    chk("to_ready", ex_ready, 1);
    drive(1, 1, 5'd15, 32'h8000_0400, 0, 0, 32'h0000_0F0F, 32'h0, 0, 32'h0);
    tick();
    idle_in();
    chk("post_to_wb_en", wb_en, 1);
    chk("post_to_wb_addr", wb_addr, 15);
    chk("post_to_wb_data", wb_data, 32'h0000_0F0F);
    chk("post_to_commit_pc", commit_pc, 32'h8000_0400);
    chk("post_to_err_sticky", timeout_err, 1);

    // asynchronous reset while a load is pending
    drive(1, 1, 5'd20, 32'h8000_0500, 1, 0, 32'h0, 32'h0, 0, 32'h0);
    tick();
    idle_in();
    tick();
    chk("ar_pre_ready", ex_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wb_en", wb_en, 0);
    chk("ar_wb_addr", wb_addr, 0);
    chk("ar_wb_data", wb_data, 0);
    chk("ar_commit", commit_valid, 0);
    chk("ar_commit_pc", commit_pc, 0);
    chk("ar_err", timeout_err, 0);
    chk("ar_ready", ex_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    lsu_valid = 1; lsu_result = 32'h7777_7777;
    tick();
    lsu_valid = 0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ar_post%0d_commit", c), commit_valid, 0);
      chk($sformatf("ar_post%0d_wb_en", c), wb_en, 0);
      chk($sformatf("ar_post%0d_ready", c), ex_ready, 1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
